mux_serializer: RTL and testbench



---
 rtl/mux_serializer_pkg.sv | 33 +++
 rtl/mux_serializer_if.sv | 29 ++
 rtl/ser_sel_counter.sv | 38 +++
 rtl/mux_serializer.sv | 121 ++++++++++++
 tb/tb_mux_serializer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_serializer_pkg.sv
// mux_serializer_pkg
//   Shared definitions for the mux_serializer slice: FSM state encoding,
//   word/select widths and the start/last bit-index helpers derived from
//   the MSB_FIRST ordering.
//   Optional feature macro: MUX_SERIALIZER_PARITY_EN (adds the PAR state).
package mux_serializer_pkg;

    localparam int unsigned SER_W = 8;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_MIN = '0;
    localparam logic [SEL_W-1:0] SEL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef MUX_SERIALIZER_PARITY_EN
        ,
        PAR
`endif
    } state_t;

    // First bit index presented in a frame.
    function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
        return msb_first ? SEL_MAX : SEL_MIN;
    endfunction

    // Final bit index of a frame; sel stops here and never wraps.
    function automatic logic [SEL_W-1:0] last_idx(input bit msb_first);
        return msb_first ? SEL_MIN : SEL_MAX;
    endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// mux_serializer_if
//   Bundles the load port and the serial port of mux_serializer.
//   master : upstream/downstream side (drives load_valid, load_data, ser_ready)
//   slave  : serializer side (drives load_ready, ser_out, ser_valid, sel,
//            busy, done)
interface mux_serializer_if;
    import mux_serializer_pkg::*;

    logic              load_valid;
    logic [SER_W-1:0]  load_data;
    logic              load_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_ready;
    logic [SEL_W-1:0]  sel;
    logic              busy;
    logic              done;

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, ser_out, ser_valid, sel, busy, done
    );

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, ser_out, ser_valid, sel, busy, done
    );

endinterface

// File: rtl/ser_sel_counter.sv
// ser_sel_counter
//   3-bit bit-index counter feeding the 8:1 select. Counts up (MSB_FIRST=0)
//   or down (MSB_FIRST=1), saturating at the last index.
//   clk, rst : clock, asynchronous active-high reset (sel -> start index)
//   load     : reload the start index
//   en       : advance one position (ignored at the last index)
//   sel      : current index
//   last     : sel is at the last index of the frame
module ser_sel_counter
    import mux_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST  = last_idx(MSB_FIRST);
    localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= START;
        end else if (load) begin
            sel <= START;
        end else if (en && !last) begin
            sel <= MSB_FIRST ? (sel - ONE) : (sel + ONE);
        end
    end

    assign last = (sel == LAST);

endmodule

// File: rtl/mux_serializer.sv
// mux_serializer
//   Parallel-to-serial frame sender in front of an 8:1 mux tree. A word is
//   captured on the load handshake, then each bit data_q[sel] is offered on
//   the serial port with its own valid/ready handshake. done pulses for one
//   cycle after the final handshake of a frame.
//   Parameters: MSB_FIRST (0: bit 0 first, 1: bit 7 first),
//               IDLE_LEVEL (ser_out value while no bit is presented).
//   Ports: clk, rst (async, active-high); bus (mux_serializer_if.slave):
//          load_valid/load_data/load_ready, ser_out/ser_valid/ser_ready,
//          sel, busy, done.
//   Macro MUX_SERIALIZER_PARITY_EN: appends an even-parity bit (PAR state).
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mux_serializer_if.slave  bus
);

    state_t            state;
    logic [SER_W-1:0]  data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              last;
    logic              ser_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              load_ready_q;
    logic              load_hs;
    logic              bit_hs;
    logic              step;
    logic              bit_out;

    // load_ready_q is high exactly in IDLE, so this also gates load_valid
    // outside IDLE.
    assign load_hs = bus.load_valid & load_ready_q;
    assign bit_hs  = ser_valid_q & bus.ser_ready;
    assign step    = bit_hs & (state == SHIFT);

    ser_sel_counter #(
        .MSB_FIRST(MSB_FIRST)
    ) u_sel (
        .clk  (clk),
        .rst  (rst),
        .load (load_hs),
        .en   (step),
        .sel  (sel_q),
        .last (last)
    );

    // Output bit depends only on registered state, never on inputs.
    always_comb begin
        bit_out = data_q[sel_q];
`ifdef MUX_SERIALIZER_PARITY_EN
        if (state == PAR) begin
            bit_out = ^data_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            data_q       <= '0;
            ser_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_hs) begin
                        data_q       <= bus.load_data;
                        state        <= SHIFT;
                        ser_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_hs && last) begin
`ifdef MUX_SERIALIZER_PARITY_EN
                        state <= PAR;
`else
                        state        <= IDLE;
                        ser_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                        done_q       <= 1'b1;
`endif
                    end
                end
`ifdef MUX_SERIALIZER_PARITY_EN
                PAR: begin
                    if (bit_hs) begin
                        state        <= IDLE;
                        ser_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                        done_q       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ser_out    = ser_valid_q ? bit_out : IDLE_LEVEL;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer
//   Directed, table-driven bench for mux_serializer. dut0 is LSB-first with
//   IDLE_LEVEL=0, dut1 is MSB-first with IDLE_LEVEL=1. Each table row gives
//   the inputs for one cycle and the outputs expected during that cycle.
//   Rows with rst=1 raise reset mid-cycle to observe its asynchronous effect.
//   Honors MUX_SERIALIZER_PARITY_EN (parity rows are added when defined).
module tb_mux_serializer;

    typedef struct packed {
        logic       w;     // 0: dut0, 1: dut1
        logic       r;     // rst
        logic       lv;
        logic [7:0] d;
        logic       rdy;
        logic       sv;
        logic       so;
        logic [2:0] sel;
        logic       busy;
        logic       done;
        logic       lr;
    } vec_t;

    logic clk;
    logic rst;

    mux_serializer_if if0 ();
    mux_serializer_if if1 ();

    mux_serializer #(
        .MSB_FIRST (1'b0),
        .IDLE_LEVEL(1'b0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    mux_serializer #(
        .MSB_FIRST (1'b1),
        .IDLE_LEVEL(1'b1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t  tbl[$];
    string tags[$];
    int    applied;
    int    miscompares;
    bit    table_done;

    task automatic add(input string tag, input bit w, input bit r, input bit lv,
                       input logic [7:0] d, input bit rdy, input bit sv,
                       input bit so, input logic [2:0] sel, input bit busy,
                       input bit done, input bit lr);
        vec_t v;
        v = '{w: w, r: r, lv: lv, d: d, rdy: rdy, sv: sv, so: so, sel: sel,
              busy: busy, done: done, lr: lr};
        tbl.push_back(v);
        tags.push_back(tag);
    endtask

    // Idle cycle: ser_out at that DUT's idle level, load_ready high.
    task automatic idle_row(input string tag, input bit w, input bit r,
                            input bit lv, input logic [7:0] d,
                            input logic [2:0] sel, input bit done);
        add(tag, w, r, lv, d, 1'b1, 1'b0, w, sel, 1'b0, done, 1'b1);
    endtask

    // Eight shift cycles with ser_ready=1 (plus parity cycle when enabled);
    // lv/dd are driven on load_valid/load_data meanwhile and must be ignored.
    task automatic frame_rows(input string tag, input bit w, input logic [7:0] d,
                              input bit lv, input logic [7:0] dd);
        logic [2:0] idx;
        for (int i = 0; i < 8; i++) begin
            idx = w ? 3'(7 - i) : 3'(i);
            add(tag, w, 1'b0, lv, dd, 1'b1, 1'b1, d[idx], idx, 1'b1, 1'b0, 1'b0);
        end
`ifdef MUX_SERIALIZER_PARITY_EN
        add({tag, " par"}, w, 1'b0, lv, dd, 1'b1, 1'b1, ^d,
            w ? 3'd0 : 3'd7, 1'b1, 1'b0, 1'b0);
`endif
    endtask

    task automatic build_table();
        // Reset state; load attempts during reset are ignored.
        idle_row("reset0", 0, 1, 1, 8'h5A, 3'd0, 0);
        idle_row("reset1", 1, 1, 1, 8'h5A, 3'd7, 0);
        idle_row("post_rst", 0, 0, 0, 8'h00, 3'd0, 0);

        // A5 LSB-first: 1,0,1,0,0,1,0,1 on sel 0..7.
        idle_row("a5 load", 0, 0, 1, 8'hA5, 3'd0, 0);
        add("a5 b0", 0, 0, 0, 8'h00, 1, 1, 1, 3'd0, 1, 0, 0);
        add("a5 b1", 0, 0, 0, 8'h00, 1, 1, 0, 3'd1, 1, 0, 0);
        add("a5 b2", 0, 0, 0, 8'h00, 1, 1, 1, 3'd2, 1, 0, 0);
        add("a5 b3", 0, 0, 0, 8'h00, 1, 1, 0, 3'd3, 1, 0, 0);
        add("a5 b4", 0, 0, 0, 8'h00, 1, 1, 0, 3'd4, 1, 0, 0);
        add("a5 b5", 0, 0, 0, 8'h00, 1, 1, 1, 3'd5, 1, 0, 0);
        add("a5 b6", 0, 0, 0, 8'h00, 1, 1, 0, 3'd6, 1, 0, 0);
        add("a5 b7", 0, 0, 0, 8'h00, 1, 1, 1, 3'd7, 1, 0, 0);
`ifdef MUX_SERIALIZER_PARITY_EN
        add("a5 par", 0, 0, 0, 8'h00, 1, 1, 0, 3'd7, 1, 0, 0);
`endif
        idle_row("a5 done", 0, 0, 0, 8'h00, 3'd7, 1);
        idle_row("a5 after", 0, 0, 0, 8'h00, 3'd7, 0);

        // 3C with ser_ready low for 3 cycles at sel=4; stray loads ignored.
        idle_row("3c load", 0, 0, 1, 8'h3C, 3'd7, 0);
        add("3c b0", 0, 0, 0, 8'h00, 1, 1, 0, 3'd0, 1, 0, 0);
        add("3c b1", 0, 0, 0, 8'h00, 1, 1, 0, 3'd1, 1, 0, 0);
        add("3c b2", 0, 0, 0, 8'h00, 1, 1, 1, 3'd2, 1, 0, 0);
        add("3c b3", 0, 0, 0, 8'h00, 1, 1, 1, 3'd3, 1, 0, 0);
        add("3c stall1", 0, 0, 1, 8'hFF, 0, 1, 1, 3'd4, 1, 0, 0);
        add("3c stall2", 0, 0, 1, 8'hFF, 0, 1, 1, 3'd4, 1, 0, 0);
        add("3c stall3", 0, 0, 1, 8'hFF, 0, 1, 1, 3'd4, 1, 0, 0);
        add("3c b4", 0, 0, 0, 8'h00, 1, 1, 1, 3'd4, 1, 0, 0);
        add("3c b5", 0, 0, 0, 8'h00, 1, 1, 1, 3'd5, 1, 0, 0);
        add("3c b6", 0, 0, 0, 8'h00, 1, 1, 0, 3'd6, 1, 0, 0);
        add("3c b7", 0, 0, 0, 8'h00, 1, 1, 0, 3'd7, 1, 0, 0);
`ifdef MUX_SERIALIZER_PARITY_EN
        add("3c par", 0, 0, 0, 8'h00, 1, 1, 0, 3'd7, 1, 0, 0);
`endif
        idle_row("3c done", 0, 0, 0, 8'h00, 3'd7, 1);

        // Back-to-back FF then 00, load_valid held: second load in done cycle.
        idle_row("ff load", 0, 0, 1, 8'hFF, 3'd7, 0);
        frame_rows("ff", 0, 8'hFF, 1, 8'h00);
        idle_row("ff done/00 load", 0, 0, 1, 8'h00, 3'd7, 1);
        frame_rows("00", 0, 8'h00, 0, 8'h00);
        idle_row("00 done", 0, 0, 0, 8'h00, 3'd7, 1);

        // E7 aborted by reset while held at sel=5, then 81 sent cleanly.
        idle_row("e7 load", 0, 0, 1, 8'hE7, 3'd7, 0);
        add("e7 b0", 0, 0, 0, 8'h00, 1, 1, 1, 3'd0, 1, 0, 0);
        add("e7 b1", 0, 0, 0, 8'h00, 1, 1, 1, 3'd1, 1, 0, 0);
        add("e7 b2", 0, 0, 0, 8'h00, 1, 1, 1, 3'd2, 1, 0, 0);
        add("e7 b3", 0, 0, 0, 8'h00, 1, 1, 0, 3'd3, 1, 0, 0);
        add("e7 b4", 0, 0, 0, 8'h00, 1, 1, 0, 3'd4, 1, 0, 0);
        add("e7 b5 hold", 0, 0, 0, 8'h00, 0, 1, 1, 3'd5, 1, 0, 0);
        idle_row("rst mid", 0, 1, 1, 8'h81, 3'd0, 0);
        idle_row("rst hold", 0, 1, 1, 8'h81, 3'd0, 0);
        idle_row("rst rel", 0, 0, 0, 8'h00, 3'd0, 0);
        idle_row("no done", 0, 0, 0, 8'h00, 3'd0, 0);
        idle_row("81 load", 0, 0, 1, 8'h81, 3'd0, 0);
        add("81 b0", 0, 0, 0, 8'h00, 1, 1, 1, 3'd0, 1, 0, 0);
        add("81 b1", 0, 0, 0, 8'h00, 1, 1, 0, 3'd1, 1, 0, 0);
        add("81 b2", 0, 0, 0, 8'h00, 1, 1, 0, 3'd2, 1, 0, 0);
        add("81 b3", 0, 0, 0, 8'h00, 1, 1, 0, 3'd3, 1, 0, 0);
        add("81 b4", 0, 0, 0, 8'h00, 1, 1, 0, 3'd4, 1, 0, 0);
        add("81 b5", 0, 0, 0, 8'h00, 1, 1, 0, 3'd5, 1, 0, 0);
        add("81 b6", 0, 0, 0, 8'h00, 1, 1, 0, 3'd6, 1, 0, 0);
        add("81 b7", 0, 0, 0, 8'h00, 1, 1, 1, 3'd7, 1, 0, 0);
`ifdef MUX_SERIALIZER_PARITY_EN
        add("81 par", 0, 0, 0, 8'h00, 1, 1, 0, 3'd7, 1, 0, 0);
`endif
        idle_row("81 done", 0, 0, 0, 8'h00, 3'd7, 1);

        // C3 MSB-first on dut1: 1,1,0,0,0,0,1,1 on sel 7..0; idle level 1.
        idle_row("c3 load", 1, 0, 1, 8'hC3, 3'd7, 0);
        add("c3 b7", 1, 0, 0, 8'h00, 1, 1, 1, 3'd7, 1, 0, 0);
        add("c3 b6", 1, 0, 0, 8'h00, 1, 1, 1, 3'd6, 1, 0, 0);
        add("c3 b5", 1, 0, 0, 8'h00, 1, 1, 0, 3'd5, 1, 0, 0);
        add("c3 b4", 1, 0, 0, 8'h00, 1, 1, 0, 3'd4, 1, 0, 0);
        add("c3 b3", 1, 0, 0, 8'h00, 1, 1, 0, 3'd3, 1, 0, 0);
        add("c3 b2", 1, 0, 0, 8'h00, 1, 1, 0, 3'd2, 1, 0, 0);
        add("c3 b1", 1, 0, 0, 8'h00, 1, 1, 1, 3'd1, 1, 0, 0);
        add("c3 b0", 1, 0, 0, 8'h00, 1, 1, 1, 3'd0, 1, 0, 0);
`ifdef MUX_SERIALIZER_PARITY_EN
        add("c3 par", 1, 0, 0, 8'h00, 1, 1, 0, 3'd0, 1, 0, 0);
`endif
        idle_row("c3 done", 1, 0, 0, 8'h00, 3'd0, 1);
        idle_row("c3 after", 1, 0, 0, 8'h00, 3'd0, 0);

`ifdef MUX_SERIALIZER_PARITY_EN
        // 07: parity bit 1; 03: parity bit 0.
        idle_row("07 load", 0, 0, 1, 8'h07, 3'd7, 0);
        frame_rows("07", 0, 8'h07, 0, 8'h00);
        idle_row("07 done", 0, 0, 1, 8'h03, 3'd7, 1);
        frame_rows("03", 0, 8'h03, 0, 8'h00);
        idle_row("03 done", 0, 0, 0, 8'h00, 3'd7, 1);
`endif
    endtask

    initial begin
        table_done = 1'b0;
        repeat (2000) @(posedge clk);
        if (!table_done) begin
            miscompares++;
            $display("FAIL timeout: only %0d of %0d vectors applied after 2000 cycles",
                     applied, tbl.size());
            $finish;
        end
    end

    initial begin
        vec_t       v;
        logic [7:0] got;
        logic [7:0] want;
        logic [7:0] got1;
        logic [7:0] want1;

        rst            = 1'b1;
        if0.load_valid = 1'b0;
        if0.load_data  = '0;
        if0.ser_ready  = 1'b1;
        if1.load_valid = 1'b0;
        if1.load_data  = '0;
        if1.ser_ready  = 1'b1;
        applied        = 0;
        miscompares    = 0;

        build_table();

        #1;
        got   = {if0.ser_valid, if0.ser_out, if0.sel, if0.busy, if0.done,
                 if0.load_ready};
        want  = {1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        got1  = {if1.ser_valid, if1.ser_out, if1.sel, if1.busy, if1.done,
                 if1.load_ready};
        want1 = {1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1};
        if (got !== want || got1 !== want1) begin
            miscompares++;
            $display("FAIL async reset state: dut0 got %b expected %b, dut1 got %b expected %b",
                     got, want, got1, want1);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst            = v.r;
            if0.load_valid = v.w ? 1'b0 : v.lv;
            if0.load_data  = v.w ? 8'h00 : v.d;
            if0.ser_ready  = v.w ? 1'b1 : v.rdy;
            if1.load_valid = v.w ? v.lv : 1'b0;
            if1.load_data  = v.w ? v.d : 8'h00;
            if1.ser_ready  = v.w ? v.rdy : 1'b1;
            #1;
            if (v.w)
                got = {if1.ser_valid, if1.ser_out, if1.sel, if1.busy,
                       if1.done, if1.load_ready};
            else
                got = {if0.ser_valid, if0.ser_out, if0.sel, if0.busy,
                       if0.done, if0.load_ready};
            want = {v.sv, v.so, v.sel, v.busy, v.done, v.lr};
            applied++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s [row %0d dut%0d]: got valid=%b out=%b sel=%0d busy=%b done=%b load_ready=%b, expected valid=%b out=%b sel=%0d busy=%b done=%b load_ready=%b",
                         tags[i], i, v.w, got[7], got[6], got[5:3], got[2],
                         got[1], got[0], want[7], want[6], want[5:3], want[2],
                         want[1], want[0]);
            end
        end
        table_done = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        if (miscompares == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
